// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packetizer / depacketizer pair.
//   START_BYTE      frame delimiter that opens every packet
//   ERR_*           err_code values reported alongside pkt_done
//   rx_state_t      byte receiver states
//   parse_state_t   packet parser states
//   csum_add        running 8-bit checksum step (sum mod 256)
package uart_pkt_pkg;

   localparam logic [7:0] START_BYTE = 8'hA5;

   localparam logic [2:0] ERR_OK       = 3'd0;
   localparam logic [2:0] ERR_BAD_LEN  = 3'd1;
   localparam logic [2:0] ERR_BAD_CSUM = 3'd2;
   localparam logic [2:0] ERR_OVERFLOW = 3'd3;
   localparam logic [2:0] ERR_FRAMING  = 3'd4;
   localparam logic [2:0] ERR_TIMEOUT  = 3'd5;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      P_WAIT_START,
      P_GET_LEN,
      P_GET_PAYLOAD,
      P_GET_CSUM
   } parse_state_t;

   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver.
//   clk, rst     system clock, asynchronous active-high reset
//   rx           serial line (idle high, asynchronous to clk)
//   rx_data      last received byte, valid while byte_valid=1
//   byte_valid   one-cycle pulse: a byte with a good stop bit arrived
//   frame_err    one-cycle pulse: stop bit sampled low, byte discarded
//   state        current receiver state, for observation
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      rx,
   output logic [7:0] rx_data,
   output logic      byte_valid,
   output logic      frame_err,
   output logic [1:0] state
);
   import uart_pkt_pkg::*;

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

   logic          rx_meta, rx_sync, rx_prev;
   rx_state_t     st, st_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shreg, shreg_n;
   logic [7:0]    rx_data_n;
   logic          byte_valid_n, frame_err_n;

   assign state = st;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_prev    <= 1'b1;
         st         <= RX_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         rx_data    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_meta    <= rx;
         rx_sync    <= rx_meta;
         rx_prev    <= rx_sync;
         st         <= st_n;
         cnt        <= cnt_n;
         bit_idx    <= bit_idx_n;
         shreg      <= shreg_n;
         rx_data    <= rx_data_n;
         byte_valid <= byte_valid_n;
         frame_err  <= frame_err_n;
      end
   end

   always_comb begin
      st_n         = st;
      cnt_n        = cnt + 1'b1;
      bit_idx_n    = bit_idx;
      shreg_n      = shreg;
      rx_data_n    = rx_data;
      byte_valid_n = 1'b0;
      frame_err_n  = 1'b0;
      case (st)
         RX_IDLE: begin
            cnt_n = '0;
            // Edge, not level: a line stuck low after a bad stop bit
            // must not retrigger a new frame.
            if (rx_prev && !rx_sync) st_n = RX_START;
         end
         RX_START: begin
            if (cnt == HALF_LAST) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               st_n      = rx_sync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt == FULL_LAST) begin
               cnt_n     = '0;
               shreg_n   = {rx_sync, shreg[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) st_n = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt == FULL_LAST) begin
               cnt_n = '0;
               st_n  = RX_IDLE;
               if (rx_sync) begin
                  byte_valid_n = 1'b1;
                  rx_data_n    = shreg;
               end else begin
                  frame_err_n = 1'b1;
               end
            end
         end
         default: st_n = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_depacketizer.sv
// UART packet receiver: START(0xA5), LEN, LEN payload bytes, CSUM.
//   clk, rst       system clock, asynchronous active-high reset
//   rx             UART serial line
//   fifo_full      full flag of the downstream FIFO
//   fifo_data      payload byte for the FIFO
//   fifo_write_en  one-cycle write strobe
//   pkt_done       one-cycle pulse when a packet completes or aborts
//   pkt_err        qualifies pkt_done, 1 = packet bad
//   err_code       cause, valid while pkt_done=1
//   busy           high from accepted START until pkt_done
// FIFO handshake: fifo_write_en is a single-cycle strobe and fifo_data is
// valid in that same cycle. There is no stall path; fifo_full is sampled
// when the byte arrives and a full FIFO causes the byte to be dropped and
// the packet to be flagged OVERFLOW.
module uart_depacketizer #(
   parameter int         CLKS_PER_BIT = 434,
   parameter int         MAX_PAYLOAD  = 16,
   parameter logic [7:0] START_BYTE   = uart_pkt_pkg::START_BYTE,
   parameter int         TIMEOUT_BITS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       fifo_full,
   output logic [7:0] fifo_data,
   output logic       fifo_write_en,
   output logic       pkt_done,
   output logic       pkt_err,
   output logic [2:0] err_code,
   output logic       busy
);
   import uart_pkt_pkg::*;

   localparam int TIMEOUT_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

   logic [7:0] rx_data;
   logic       byte_valid, frame_err;
   logic [1:0] rx_state;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_data    (rx_data),
      .byte_valid (byte_valid),
      .frame_err  (frame_err),
      .state      (rx_state)
   );

   parse_state_t  state, state_n;
   logic [7:0]    len, len_n, cnt, cnt_n, csum, csum_n;
   logic          ovf, ovf_n;
   logic [TW-1:0] timer, timer_n;
   logic [7:0]    fifo_data_n;
   logic          fifo_write_en_n, pkt_done_n, pkt_err_n, busy_n;
   logic [2:0]    err_code_n, fin_code;
   logic          finish;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= P_WAIT_START;
         len           <= '0;
         cnt           <= '0;
         csum          <= '0;
         ovf           <= 1'b0;
         timer         <= '0;
         fifo_data     <= '0;
         fifo_write_en <= 1'b0;
         pkt_done      <= 1'b0;
         pkt_err       <= 1'b0;
         err_code      <= '0;
         busy          <= 1'b0;
      end else begin
         state         <= state_n;
         len           <= len_n;
         cnt           <= cnt_n;
         csum          <= csum_n;
         ovf           <= ovf_n;
         timer         <= timer_n;
         fifo_data     <= fifo_data_n;
         fifo_write_en <= fifo_write_en_n;
         pkt_done      <= pkt_done_n;
         pkt_err       <= pkt_err_n;
         err_code      <= err_code_n;
         busy          <= busy_n;
      end
   end

   always_comb begin
      state_n         = state;
      len_n           = len;
      cnt_n           = cnt;
      csum_n          = csum;
      ovf_n           = ovf;
      timer_n         = '0;
      fifo_data_n     = fifo_data;
      fifo_write_en_n = 1'b0;
      pkt_done_n      = 1'b0;
      pkt_err_n       = 1'b0;
      err_code_n      = ERR_OK;
      busy_n          = busy;
      finish          = 1'b0;
      fin_code        = ERR_OK;

      // Idle timer only runs mid-packet and restarts on every good byte.
      if (busy) timer_n = byte_valid ? '0 : timer + 1'b1;

      case (state)
         P_WAIT_START: begin
            if (byte_valid && rx_data == START_BYTE) begin
               state_n = P_GET_LEN;
               busy_n  = 1'b1;
            end
         end
         P_GET_LEN: begin
            if (byte_valid) begin
               if (rx_data == 8'd0 || rx_data > MAX_LEN) begin
                  finish   = 1'b1;
                  fin_code = ERR_BAD_LEN;
               end else begin
                  len_n   = rx_data;
                  cnt_n   = '0;
                  csum_n  = '0;
                  ovf_n   = 1'b0;
                  state_n = P_GET_PAYLOAD;
               end
            end
         end
         P_GET_PAYLOAD: begin
            if (byte_valid) begin
               csum_n = csum_add(csum, rx_data);
               if (fifo_full) begin
                  ovf_n = 1'b1;
               end else begin
                  fifo_data_n     = rx_data;
                  fifo_write_en_n = 1'b1;
               end
               cnt_n = cnt + 8'd1;
               if (cnt_n == len) state_n = P_GET_CSUM;
            end
         end
         P_GET_CSUM: begin
            if (byte_valid) begin
               finish = 1'b1;
               if (ovf)                  fin_code = ERR_OVERFLOW;
               else if (rx_data != csum) fin_code = ERR_BAD_CSUM;
               else                      fin_code = ERR_OK;
            end
         end
         default: state_n = P_WAIT_START;
      endcase

      // frame_err and byte_valid never coincide, so these cannot override
      // a byte-driven result.
      if (busy && frame_err) begin
         finish   = 1'b1;
         fin_code = ERR_FRAMING;
      end else if (busy && !byte_valid && timer == TIMER_LAST) begin
         finish   = 1'b1;
         fin_code = ERR_TIMEOUT;
      end

      if (finish) begin
         state_n    = P_WAIT_START;
         busy_n     = 1'b0;
         timer_n    = '0;
         pkt_done_n = 1'b1;
         pkt_err_n  = (fin_code != ERR_OK);
         err_code_n = fin_code;
      end
   end

endmodule

// File: doc/uart_depacketizer.md
Name: uart_depacketizer

Overview:
Receive-side counterpart of the UART packetizer. It deserialises 8N1 UART bytes from the rx line and parses framed packets of the form START(0xA5), LEN, LEN payload bytes, CSUM. Each payload byte is streamed into the downstream fifo_buffer through its write port. A per-packet status pulse reports success or the error cause.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4
MAX_PAYLOAD, 16, largest legal LEN value (1..255)
START_BYTE, 8'hA5, frame delimiter
TIMEOUT_BITS, 20, mid-packet idle limit in bit-times before abort

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx  input  1  UART serial line, idle high, asynchronous to clk
fifo_full  input  1  full flag from downstream fifo_buffer
fifo_data  output  8  payload byte to FIFO data_in
fifo_write_en  output  1  one-cycle write strobe to FIFO
pkt_done  output  1  one-cycle pulse at end or abort of a packet
pkt_err  output  1  qualifies pkt_done: 1 = packet bad
err_code  output  3  cause, valid while pkt_done=1
busy  output  1  high from START accepted until pkt_done

Behaviour:
Interface: one clock, clk; rst is asynchronous and active-high. All flops clear on rst assertion.
- Reset values: fifo_data=0, fifo_write_en=0, pkt_done=0, pkt_err=0, err_code=0, busy=0. Synchroniser flops reset to 1. Both FSMs reset to idle. A reset mid-packet discards all parser state. Bytes already written stay in the FIFO.
- rx passes through a 2-flop synchroniser before any use.
- Byte receiver FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge on synced rx starts a count of CLKS_PER_BIT/2 cycles.
  - START: at mid-start-bit, rx=1 is treated as a glitch and the FSM returns to IDLE.
  - DATA: 8 bits, LSB first, each sampled every CLKS_PER_BIT cycles at mid-bit.
  - STOP: sampled at mid-bit. rx=1 gives byte_valid for 1 cycle. rx=0 gives frame_err for 1 cycle and no byte.
  - After the stop sample the FSM returns to IDLE immediately, so back-to-back frames are accepted.
- Parser FSM: WAIT_START, GET_LEN, GET_PAYLOAD, GET_CSUM.
  - WAIT_START: bytes other than START_BYTE are silently ignored. START_BYTE sets busy=1 and moves to GET_LEN.
  - GET_LEN: LEN=0 or LEN>MAX_PAYLOAD aborts with BAD_LEN. Otherwise latch LEN, clear the 8-bit checksum accumulator and the overflow flag, and move to GET_PAYLOAD.
  - GET_PAYLOAD: each byte adds to the checksum (8-bit sum, mod 256, wraps). If fifo_full=0, drive fifo_data=byte and fifo_write_en=1 for exactly one cycle, 1 cycle after byte_valid. If fifo_full=1, drop the byte and set the sticky overflow flag. Move to GET_CSUM after LEN bytes.
  - GET_CSUM: result priority is OVERFLOW > BAD_CSUM > OK.
- err_code values: 0 OK, 1 BAD_LEN, 2 BAD_CSUM, 3 OVERFLOW, 4 FRAMING, 5 TIMEOUT.
- frame_err while busy aborts with FRAMING. frame_err in WAIT_START is ignored.
- Timeout: a counter restarts on every byte_valid while busy. Reaching TIMEOUT_BITS*CLKS_PER_BIT cycles aborts with TIMEOUT.
- Every abort or completion:
  - pkt_done=1 for one cycle, with pkt_err=(err_code!=0).
  - busy drops in the same cycle.
  - Parser returns to WAIT_START.
- A START_BYTE arriving as payload or LEN is data, not resync.
- Latency: the stop-bit sample cycle is T. fifo_write_en occurs at T+2. pkt_done for a completed packet occurs at T+2 of the CSUM byte.
- The counter in the byte receiver is wide enough for CLKS_PER_BIT; the payload counter is 8 bits.

Decomposition:
- Shared package uart_pkt_pkg holds the following, shared with the packetizer: START_BYTE, the err_code localparams, the state encodings, and the checksum function.
- Natural sub-module: uart_rx_byte (synchroniser + byte receiver FSM). Its outputs are byte, byte_valid and frame_err.
- uart_depacketizer instantiates uart_rx_byte and holds the parser.

Test Plan:
- CLKS_PER_BIT=8. Send A5 03 11 22 33 66 -> fifo_write_en three times with 11, 22, 33; then pkt_done=1, pkt_err=0, err_code=0; busy low afterwards.
- Same packet with CSUM 67 -> three writes still occur; pkt_done with err_code=2.
- Send A5 00, then A5 11 with MAX_PAYLOAD=16 -> each gives pkt_done, err_code=1, no writes. A following valid packet is received correctly.
- Hold fifo_full=1 during the 2nd payload byte of A5 03 11 22 33 66 -> only 11 and 33 written; err_code=3.
- Stop bit forced 0 on the LEN byte -> err_code=4. A 3-cycle low glitch on idle rx -> no byte_valid, no pkt_done.
- Stop after A5 02 11 -> pkt_done with err_code=5 after 160 idle cycles. Separately, assert rst mid-payload -> all outputs 0 within the same cycle and busy=0; the next clean packet passes.
